mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath; sits directly downstream of the register file.
- Consumes the Rs_data/Rt_data read-port values of the register file.
- Executes MULT/MULTU/DIV/DIVU over 32 cycles, plus single-cycle MTHI/MTLO.
- Holds the architectural HI/LO registers, which the writeback mux reads for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration count per mul/div; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on posedge only when busy=0.
- op  input  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110/111 are no-ops.
- Rs_data  input  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source.
- Rt_data  input  WIDTH  operand B: multiplier or divisor.
- busy  output  1  high while a mul/div is in progress.
- done  output  1  one-cycle pulse when a mul/div result is written to HI/LO.
- HI  output  WIDTH  HI register: product upper word or remainder.
- LO  output  WIDTH  LO register: product lower word or quotient.

Behaviour:
- Reset: at a posedge with rst=1:
  - state=IDLE; busy=0, done=0, HI=0, LO=0.
  - Iteration counter and working registers cleared.
  - An in-flight operation is aborted with no HI/LO update.
  - rst overrides start in the same cycle.
- States: IDLE, MUL, DIV.
- IDLE, with start=1 at posedge E0:
  - op 000/001: latch operands, go to MUL, busy=1.
  - op 010/011: latch operands, go to DIV, busy=1.
  - op 100: HI<=Rs_data at E0; stay IDLE; busy and done stay 0.
  - op 101: LO<=Rs_data at E0; stay IDLE; busy and done stay 0.
  - op 110/111: no effect.
- Operands are latched at E0; later changes on Rs_data/Rt_data have no effect on the result.
- MUL/DIV: one iteration per posedge, E1..E32.
  - At E32: HI/LO written, busy<=0, done<=1, state<=IDLE.
  - done drops at E33 unless a new op completes there (impossible, since minimum latency is 32).
- Latency: result visible on HI/LO from E32, 32 cycles after acceptance. HI/LO hold their old values during E1..E31.
- start while busy=1 is ignored, including MTHI/MTLO; it is not queued.
- start while done=1 is accepted, since busy=0 in that cycle.
- Multiply:
  - Shift-add on magnitudes, 64-bit product.
  - Signed (MULT): negate the 64-bit result if the operand signs differ.
  - {HI,LO} = product.
- Divide:
  - Restoring division on magnitudes.
  - Signed (DIV): quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- Divide by zero (either signedness):
  - Full 32-cycle latency.
  - HI = original Rs_data, LO = 0xFFFFFFFF.
  - done pulses normally.
- Arithmetic: all intermediate values are exact, with no saturation. Unsigned ops treat bit 31 as magnitude.

Test Plan:
- Reset then MULTU with Rs=0xFFFFFFFF, Rt=0xFFFFFFFF -> busy=1 for cycles E1..E31, done=1 exactly one cycle after E32, HI=0xFFFFFFFE, LO=0x00000001.
- MULT with Rs=0xFFFFFFFD (-3), Rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV with Rs=0xFFFFFFF9 (-7), Rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with Rs=7, Rt=0 -> after 32 cycles HI=7, LO=0xFFFFFFFF.
- MTHI Rs=0x12345678, next cycle MTLO Rs=0x9ABCDEF0 -> HI/LO updated on the accepting edges with no busy or done activity. Then start MULTU 2*3, and at E5 assert start with MTHI Rs=0xDEADBEEF -> ignored; final HI=0, LO=6.
- MULTU 4*4 started, rst=1 at E10 -> at E10 busy=0, done=0, HI=0, LO=0, with no later done pulse. A fresh DIVU 100/7 then yields LO=14, HI=2.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-cycle multiply/divide unit holding the
// architectural HI/LO registers. MULT/MULTU use shift-add on operand
// magnitudes, DIV/DIVU use restoring division on magnitudes, and signs are
// applied to the result on the final iteration. MTHI/MTLO write in one cycle.
//
// Handshake: start is sampled on a posedge only while busy=0. A mul/div that
// is accepted at edge E0 raises busy at E0 and runs one iteration per edge
// E1..E32. At E32 it writes HI/LO, drops busy and pulses done for one cycle.
// start while busy=1 is dropped, not queued.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Rs_data,
  input  logic [WIDTH-1:0] Rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic [2*WIDTH-1:0]  r_prod;
  logic [WIDTH-1:0]    r_rem;
  logic [WIDTH-1:0]    r_quo;
  logic [WIDTH-1:0]    r_divisor;
  logic [WIDTH-1:0]    r_a_raw;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_dz;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic                r_done;

  logic                w_last;
  logic                w_signed;
  logic [WIDTH-1:0]    w_mag_a;
  logic [WIDTH-1:0]    w_mag_b;
  logic [2*WIDTH-1:0]  w_prod_step;
  logic [2*WIDTH-1:0]  w_prod_fin;
  logic [WIDTH:0]      w_shift;
  logic [WIDTH:0]      w_sub;
  logic [WIDTH-1:0]    w_rem_step;
  logic [WIDTH-1:0]    w_quo_step;
  logic [WIDTH-1:0]    w_rem_fin;
  logic [WIDTH-1:0]    w_quo_fin;

  assign w_last   = (r_cnt == CW'(ITER - 1));
  // op[0]=0 selects the signed flavour of both MULT and DIV.
  assign w_signed = ~op[0];
  assign w_mag_a  = (w_signed && Rs_data[WIDTH-1]) ? -Rs_data : Rs_data;
  assign w_mag_b  = (w_signed && Rt_data[WIDTH-1]) ? -Rt_data : Rt_data;

  // One multiply iteration, and the signed fix-up applied on the last one.
  assign w_prod_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign w_prod_fin  = r_neg_q ? -w_prod_step : w_prod_step;

  // One restoring-divide iteration; the remainder stays below the divisor,
  // so a failed trial subtraction never leaves a bit in w_shift[WIDTH].
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_sub      = w_shift - {1'b0, r_divisor};
  assign w_rem_step = w_sub[WIDTH] ? w_shift[WIDTH-1:0] : w_sub[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], ~w_sub[WIDTH]};
  assign w_quo_fin  = r_neg_q ? -w_quo_step : w_quo_step;
  assign w_rem_fin  = r_neg_r ? -w_rem_step : w_rem_step;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: launch mul/div from IDLE, return to IDLE after the last iteration.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001: w_next = S_MUL;
            3'b010, 3'b011: w_next = S_DIV;
            default:        w_next = S_IDLE;
          endcase
        end
      end
      S_MUL, S_DIV: if (w_last) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iterations, HI/LO writes and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_a_raw   <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_cnt     <= '0;
                r_prod    <= '0;
                r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier  <= w_mag_b;
                r_rem     <= '0;
                r_quo     <= w_mag_a;
                r_divisor <= w_mag_b;
                r_a_raw   <= Rs_data;
                r_dz      <= (Rt_data == '0);
                r_neg_q   <= w_signed & (Rs_data[WIDTH-1] ^ Rt_data[WIDTH-1]);
                r_neg_r   <= w_signed & Rs_data[WIDTH-1];
              end
              3'b100:  r_hi <= Rs_data;
              3'b101:  r_lo <= Rs_data;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi   <= w_prod_fin[2*WIDTH-1:WIDTH];
            r_lo   <= w_prod_fin[WIDTH-1:0];
            r_done <= 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // Divide by zero still takes the full latency, then reports
            // the untouched dividend in HI and all ones in LO.
            r_hi   <= r_dz ? r_a_raw : w_rem_fin;
            r_lo   <= r_dz ? {WIDTH{1'b1}} : w_quo_fin;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus randomized ops, checked against
// a plain-arithmetic reference model through an expected-result queue that a
// separate monitor drains on every done pulse.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  rs;
  logic [W-1:0]  rt;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   ref_hi;
  logic [W-1:0]   ref_lo;

  mul_div_unit #(.WIDTH(W), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .Rs_data(rs), .Rt_data(rt),
    .busy(busy), .done(done), .HI(hi), .LO(lo)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: exact 64-bit arithmetic on the architectural rules.
  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2, 3'd3: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Driver: call at a negedge; presents one request for the next posedge.
  // accept=1 means the bench expects the unit to take it (unit idle).
  task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
    logic [2*W-1:0] e;
    op = o; rs = a; rt = b; start = 1'b1;
    if (accept) begin
      if (o < 3'd4) begin
        e = model(o, a, b);
        exp_q.push_back(e);
        ref_hi = e[2*W-1:W];
        ref_lo = e[W-1:0];
      end else if (o == 3'd4) ref_hi = a;
      else if (o == 3'd5) ref_lo = a;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    rs = $urandom;
    rt = $urandom;
  endtask

  // Wait for done with a cycle budget; checks latency and busy duration.
  task automatic wait_done(input string name, input int lat);
    int k = 0;
    int busy_n = 0;
    while (k < 100) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_n++;
      k++;
    end
    check({name, "_latency"}, k, lat);
    check({name, "_busy_cycles"}, busy_n, lat);
  endtask

  task automatic check_idle_regs(input string name);
    check({name, "_hi"}, hi, ref_hi);
    check({name, "_lo"}, lo, ref_lo);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 required no pulse (HI=%h LO=%h)", hi, lo);
      end else begin
        check("result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [2:0]   o;
    logic [W-1:0] a, b;
    logic [W-1:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

    rst = 1'b1; start = 1'b0; op = 3'd0; rs = '0; rt = '0;
    ref_hi = '0; ref_lo = '0;
    repeat (3) @(negedge clk);
    check_idle_regs("reset");
    rst = 1'b0;

    // MULTU max*max
    drive(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("multu_max", 32);
    check("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // MULT -3*5 (accepted in the done cycle)
    drive(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done("mult_neg", 32);
    check("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // DIV -7/2
    drive(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div_neg", 32);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIVU 7/0
    drive(3'd3, 32'd7, 32'd0, 1'b1);
    wait_done("divu_zero", 32);
    check("divu_zero_hilo", {hi, lo}, 64'h0000_0007_FFFF_FFFF);

    // DIV 0x80000000 / -1
    drive(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_ovf", 32);
    check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI then MTLO on back-to-back edges
    drive(3'd4, 32'h1234_5678, 32'd0, 1'b1);
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check_idle_regs("mthi");
    drive(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b1);
    @(negedge clk);
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check_idle_regs("mtlo");

    // MULTU 2*3 with an MTHI at E5 that must be dropped
    drive(3'd1, 32'd2, 32'd3, 1'b1);
    repeat (5) @(negedge clk);
    drive(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
    @(negedge clk);
    check("busy_mthi_hi_hold", hi, 32'h1234_5678);
    check("busy_mthi_busy", busy, 1'b1);
    wait_done("multu_small", 26);
    check("multu_small_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    // Reset aborts MULTU 4*4 at E10
    drive(3'd1, 32'd4, 32'd4, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    ref_hi = '0; ref_lo = '0;
    check_idle_regs("abort");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_idle_regs("abort_quiet");
    drive(3'd3, 32'd100, 32'd7, 1'b1);
    wait_done("divu_after_rst", 32);
    check("divu_after_rst_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      drive(o, a, b, 1'b1);
      if (o < 3'd4) begin
        wait_done("rand_op", 32);
        check("rand_hilo", {hi, lo}, {ref_hi, ref_lo});
      end else begin
        @(negedge clk);
        check_idle_regs("rand_single");
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
